seq_divider: RTL and testbench

Parametrised, iterative unsigned integer divider. It computes quotient and remainder of a DW-bit dividend by a VW-bit divisor using restoring division. It retires one quotient bit per clock, MSB first, under a start/done handshake. It succeeds the combinational array divider wherever area matters more than latency, and adds width parameters, operand capture, busy/done signalling and explicit divide-by-zero detection.

---
 rtl/seq_divider.sv | 142 ++++++++++++++
 tb/tb_seq_divider.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring unsigned divider, one quotient bit per clock
//
// Computes q = x / y and r = x % y for a DW-bit dividend and VW-bit divisor.
// A start sampled while idle captures x and y; the result commits DW cycles
// later with a one-cycle done pulse. A zero divisor commits immediately with
// q = all ones, r = 0 and div_zero = 1.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   request a division (ignored while busy)
//   x         in   DW-bit dividend, captured on the accepting edge
//   y         in   VW-bit divisor, captured on the accepting edge
//   busy      out  division in progress
//   done      out  one-cycle pulse: q, r, div_zero just updated
//   q         out  DW-bit quotient, registered
//   r         out  VW-bit remainder, registered
//   div_zero  out  last committed result was a divide by zero

module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] x,
  input  logic [VW-1:0] y,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          div_zero
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;   // shifts dividend out of the MSB, quotient in at the LSB
  logic [VW-1:0] div_q, div_d;
  logic [VW-1:0] rem_q, rem_d;   // partial remainder; always < divisor so VW bits suffice
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic          dz_q, dz_d;

  logic [VW:0]   p;
  logic          ge;
  logic [VW-1:0] rem_step;
  logic [DW-1:0] dvd_step;

  always_comb begin
    // VW+1 bit trial value so the bit shifted in from the dividend is kept.
    p        = {rem_q, dvd_q[DW-1]};
    ge       = (p >= {1'b0, div_q});
    // When p >= divisor the difference is < divisor, so the low VW bits are exact.
    rem_step = ge ? (p[VW-1:0] - div_q) : p[VW-1:0];
    dvd_step = {dvd_q[DW-2:0], ge};

    state_d = state_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (y == '0) begin
            q_d    = '1;
            r_d    = '0;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            dvd_d   = x;
            div_d   = y;
            rem_d   = '0;
            cnt_d   = CW'(DW);
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = dvd_step;
        rem_d = rem_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = dvd_step;
          r_d     = rem_step;
          dz_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and exhaustive self-checking bench for seq_divider

module tb_seq_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] x;
  logic [VW-1:0] y;
  logic          busy;
  logic          done;
  logic [DW-1:0] q;
  logic [VW-1:0] r;
  logic          div_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one start, then returns at the negedge of the done cycle (or after a bound).
  // lat is the cycle index of done relative to the accepting edge, -1 on timeout.
  task automatic run_div(input logic [DW-1:0] xa, input logic [VW-1:0] ya,
                         output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; x = xa; y = ya;
    @(negedge clk);
    start = 1'b0; x = DW'($urandom); y = VW'($urandom);
    lat = -1; bcnt = 0;
    for (int k = 0; k < DW + 4; k++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bcnt, remaining, ndone, seen;
    logic [DW-1:0] eq;
    logic [VW-1:0] er;

    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_dz", div_zero, 0);

    // Main vector: 200 / 7 = 28 rem 4
    run_div(8'd200, 4'd7, lat, bcnt);
    chk("v200_7_lat", lat, 8);
    chk("v200_7_busy", bcnt, 8);
    chk("v200_7_q", q, 28);
    chk("v200_7_r", r, 4);
    chk("v200_7_dz", div_zero, 0);

    run_div(8'd255, 4'd1, lat, bcnt);
    chk("v255_1_q", q, 255); chk("v255_1_r", r, 0);
    run_div(8'd5, 4'd9, lat, bcnt);
    chk("v5_9_q", q, 0); chk("v5_9_r", r, 5);
    run_div(8'd0, 4'd15, lat, bcnt);
    chk("v0_15_q", q, 0); chk("v0_15_r", r, 0);
    run_div(8'd255, 4'd15, lat, bcnt);
    chk("v255_15_q", q, 17); chk("v255_15_r", r, 0);

    // Divide by zero commits in cycle 0 without ever raising busy.
    run_div(8'd100, 4'd0, lat, bcnt);
    chk("dz_lat", lat, 0);
    chk("dz_busy", bcnt, 0);
    chk("dz_q", q, 255);
    chk("dz_r", r, 0);
    chk("dz_flag", div_zero, 1);
    run_div(8'd9, 4'd3, lat, bcnt);
    chk("v9_3_q", q, 3); chk("v9_3_r", r, 0); chk("v9_3_dz", div_zero, 0);

    // Mid-CALC start is ignored and old results hold until commit.
    @(negedge clk);
    start = 1'b1; x = 8'd200; y = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; x = 8'd1; y = 4'd1;
    chk("hold_q", q, 3);
    chk("hold_r", r, 0);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 3; k < DW + 4; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk("mid_lat", lat, 8);
    chk("mid_q", q, 28);
    chk("mid_r", r, 4);
    seen = 0;
    for (int k = 0; k < DW + 3; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("mid_nodone", seen, 0);

    // start held high with operands changing every cycle.
    remaining = 0; ndone = 0; eq = '0; er = '0;
    for (int c = 0; c < 20 + DW + 3; c++) begin
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          ndone++;
          chk("held_done", done, 1);
          chk("held_q", q, eq);
          chk("held_r", r, er);
        end else begin
          chk("held_idle", done, 0);
        end
      end
      start = (c < 20);
      x = DW'($urandom);
      y = VW'($urandom_range(15, 1));
      if (remaining == 0 && start) begin
        eq = x / y;
        er = x % y;
        remaining = DW + 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_cnt", ndone, 3);

    // Reset in cycle 4 of a division aborts it.
    @(negedge clk);
    start = 1'b1; x = 8'd200; y = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_q", q, 0);
    chk("ar_r", r, 0);
    chk("ar_dz", div_zero, 0);
    seen = 0;
    for (int k = 0; k < DW + 3; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("ar_nodone", seen, 0);
    run_div(8'd9, 4'd3, lat, bcnt);
    chk("ar_fresh_q", q, 3);
    chk("ar_fresh_lat", lat, 8);

    // Exhaustive sweep against golden arithmetic.
    for (int xi = 0; xi < (1 << DW); xi++) begin
      for (int yi = 0; yi < (1 << VW); yi++) begin
        run_div(DW'(xi), VW'(yi), lat, bcnt);
        if (yi == 0) begin
          chk("ex_q", q, (1 << DW) - 1);
          chk("ex_r", r, 0);
          chk("ex_dz", div_zero, 1);
          chk("ex_lat", lat, 0);
        end else begin
          chk("ex_q", q, xi / yi);
          chk("ex_r", r, xi % yi);
          chk("ex_dz", div_zero, 0);
          chk("ex_lat", lat, DW);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
